fitness_eval: RTL and testbench

- Sequential test harness for one evolved combinational circuit: the logic_e-cell netlist produced by the genetic flow (default 3 inputs, 2 outputs).
- On start, drives every input vector 0..2^IN_W-1 into the circuit, waits a settle time, samples the circuit outputs and compares them bitwise against a target truth table.
- Reports the number of matching output bits as the fitness score to the GA controller.
- Sits directly around the evolved circuit: feeds its inputs and consumes its outputs.

---
 rtl/fitness_eval.sv | 178 +++++++++++++++++
 tb/tb_fitness_eval.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fitness_eval.sv
// fitness_eval: sequential test harness for one evolved combinational circuit.
// It sweeps every input vector 0..2^IN_W-1 into the circuit and holds each one
// for SETTLE cycles. It then samples the circuit outputs and counts how many
// output bits agree with a target truth table. The final count goes to the GA
// controller as the fitness score.
//
// Optional build macro: FITNESS_ERR_MAP_EN adds the err_map output, which gives
// one bit per input vector, set when any output bit of that vector mismatched.
//
// Ports:
//   clk      in   single clock, rising edge
//   rst_n    in   synchronous active-low reset
//   start    in   request an evaluation (honoured only when idle)
//   target   in   expected truth table, entry v at [v*OUT_W +: OUT_W]
//   dut_in   out  registered drive to the evolved circuit's inputs
//   dut_out  in   evolved circuit's outputs (combinational)
//   busy     out  evaluation in progress, including the done cycle
//   done     out  one-cycle pulse when fitness/perfect are valid
//   fitness  out  matching-bit count of the last completed run
//   perfect  out  fitness equals the total number of truth-table bits
//   err_map  out  (FITNESS_ERR_MAP_EN only) per-vector mismatch flags
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start; outputs of the last run are held
// APPLY  | dut_in = vec, counting settle cycles
// SAMPLE | compare dut_out with the target entry for vec, accumulate
// DONE   | single-cycle done pulse; fitness/perfect already updated
`timescale 1ns/1ps

module fitness_eval #(
  parameter int IN_W   = 3,
  parameter int OUT_W  = 2,
  parameter int SETTLE = 1
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      start,
  input  logic [OUT_W*(2**IN_W)-1:0]                target,
  output logic [IN_W-1:0]                           dut_in,
  input  logic [OUT_W-1:0]                          dut_out,
  output logic                                      busy,
  output logic                                      done,
  output logic [$clog2(OUT_W*(2**IN_W)+1)-1:0]      fitness,
  output logic                                      perfect
`ifdef FITNESS_ERR_MAP_EN
  ,
  output logic [(2**IN_W)-1:0]                      err_map
`endif
);

  localparam int NV    = 2**IN_W;
  localparam int TT_W  = OUT_W*NV;
  localparam int FIT_W = $clog2(TT_W+1);

  localparam logic [IN_W:0]      LAST_VEC  = (IN_W+1)'(NV-1);
  localparam logic [3:0]         SETTLE_TC = 4'(SETTLE-1);
  localparam logic [FIT_W-1:0]   FIT_MAX   = FIT_W'(TT_W);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_APPLY  = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [TT_W-1:0]  tgt_q;
  // One bit wider than the vector index so the last-vector compare never wraps.
  logic [IN_W:0]    vec;
  logic [IN_W:0]    vec_nxt;
  logic [3:0]       settle_cnt;
  logic [FIT_W-1:0] acc;

  logic [OUT_W-1:0] cur_tgt;
  logic [OUT_W-1:0] mismatch;
  logic [OUT_W-1:0] match_bits;
  logic [FIT_W-1:0] match_cnt;
  logic [FIT_W-1:0] acc_sum;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_APPLY;
      S_APPLY:  if (settle_cnt == SETTLE_TC) state_nxt = S_SAMPLE;
      S_SAMPLE: state_nxt = (vec == LAST_VEC) ? S_DONE : S_APPLY;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state != S_IDLE);
    done = (state == S_DONE);
  end

  // Compare the current target entry against the circuit outputs.
  always_comb begin
    cur_tgt = '0;
    for (int v = 0; v < NV; v++) begin
      if (vec[IN_W-1:0] == IN_W'(v)) cur_tgt = tgt_q[v*OUT_W +: OUT_W];
    end
    mismatch   = dut_out ^ cur_tgt;
    match_bits = ~mismatch;
    match_cnt  = '0;
    for (int b = 0; b < OUT_W; b++) begin
      match_cnt = match_cnt + {{(FIT_W-1){1'b0}}, match_bits[b]};
    end
    acc_sum = acc + match_cnt;
    vec_nxt = vec + 1'b1;
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tgt_q      <= '0;
      vec        <= '0;
      settle_cnt <= '0;
      acc        <= '0;
      dut_in     <= '0;
      fitness    <= '0;
      perfect    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            tgt_q      <= target;
            vec        <= '0;
            acc        <= '0;
            dut_in     <= '0;
            settle_cnt <= '0;
          end
        end
        S_APPLY: begin
          if (settle_cnt != SETTLE_TC) settle_cnt <= settle_cnt + 4'd1;
        end
        S_SAMPLE: begin
          acc <= acc_sum;
          if (vec == LAST_VEC) begin
            // Publish on the edge into DONE so the result is valid with done.
            fitness <= acc_sum;
            perfect <= (acc_sum == FIT_MAX);
          end else begin
            vec        <= vec_nxt;
            dut_in     <= vec_nxt[IN_W-1:0];
            settle_cnt <= '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef FITNESS_ERR_MAP_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_map <= '0;
    end else if (state == S_IDLE && start) begin
      err_map <= '0;
    end else if (state == S_SAMPLE) begin
      err_map[vec[IN_W-1:0]] <= |mismatch;
    end
  end
`else
  // Error map not built: per-vector mismatch flags are not retained.
`endif

endmodule

// File: tb/tb_fitness_eval.sv
`timescale 1ns/1ps

module tb_fitness_eval;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start_a, start_b;
  logic [15:0] target_a, target_b;
  logic [2:0]  in_a, in_b;
  logic [1:0]  out_a, out_b;
  logic        busy_a, busy_b, done_a, done_b, perf_a, perf_b;
  logic [4:0]  fit_a, fit_b;
`ifdef FITNESS_ERR_MAP_EN
  logic [7:0]  err_a, err_b;
`endif

  // Circuit model: a truth table looked up by the applied input vector.
  // The "slow" variant puts two register stages between dut_in and the lookup,
  // so the output lags the applied vector by one more cycle than a SETTLE=1
  // sample window covers (dut_in itself is already registered).
  logic [15:0] circ;
  bit          dly_a;
  logic [2:0]  a_d1, a_d2, b_d1, b_d2;

  always @(posedge clk) begin
    a_d1 <= in_a;
    a_d2 <= a_d1;
    b_d1 <= in_b;
    b_d2 <= b_d1;
  end

  function automatic logic [1:0] circ_f(input logic [15:0] t, input logic [2:0] x);
    return t[x*2 +: 2];
  endfunction

  assign out_a = circ_f(circ, dly_a ? a_d2 : in_a);
  assign out_b = circ_f(circ, b_d2);

  fitness_eval u_dut (
    .clk(clk), .rst_n(rst_n), .start(start_a), .target(target_a),
    .dut_in(in_a), .dut_out(out_a), .busy(busy_a), .done(done_a),
    .fitness(fit_a), .perfect(perf_a)
`ifdef FITNESS_ERR_MAP_EN
    , .err_map(err_a)
`endif
  );

  fitness_eval #(.SETTLE(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start_b), .target(target_b),
    .dut_in(in_b), .dut_out(out_b), .busy(busy_b), .done(done_b),
    .fitness(fit_b), .perfect(perf_b)
`ifdef FITNESS_ERR_MAP_EN
    , .err_map(err_b)
`endif
  );

  // Observation mux: sel picks which instance the directed steps look at.
  bit          sel;
  logic        busy_o, done_o, perf_o;
  logic [4:0]  fit_o;
  assign busy_o = sel ? busy_b : busy_a;
  assign done_o = sel ? done_b : done_a;
  assign perf_o = sel ? perf_b : perf_a;
  assign fit_o  = sel ? fit_b  : fit_a;
`ifdef FITNESS_ERR_MAP_EN
  logic [7:0]  err_o;
  assign err_o  = sel ? err_b  : err_a;
`endif

  // Reference model: count agreeing truth-table bits / mismatching entries.
  function automatic int ref_fit(input logic [15:0] c, input logic [15:0] t);
    int n = 0;
    for (int i = 0; i < 16; i++) if (c[i] == t[i]) n++;
    return n;
  endfunction

  function automatic logic [7:0] ref_err(input logic [15:0] c, input logic [15:0] t);
    logic [7:0] m;
    for (int v = 0; v < 8; v++) m[v] = (c[v*2 +: 2] != t[v*2 +: 2]);
    return m;
  endfunction

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive a one-cycle start; returns in cycle 1 of the run.
  task automatic launch(input logic [15:0] tgt);
    if (sel) begin
      start_b = 1'b1; target_b = tgt;
    end else begin
      start_a = 1'b1; target_a = tgt;
    end
    step();
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  // Returns in the done cycle; dc = its number (0 if never seen), bc = busy cycles before it.
  task automatic wait_done(input int max_c, output int dc, output int bc);
    dc = 0;
    bc = 0;
    for (int n = 1; n <= max_c; n++) begin
      if (done_o) begin
        dc = n;
        break;
      end
      if (busy_o) bc++;
      step();
    end
  endtask

  task automatic check_run(input string tag, input logic [15:0] c, input logic [15:0] t,
                           input int exp_dc);
    int dc, bc;
    launch(t);
    wait_done(80, dc, bc);
    chk({tag, "_done_cyc"}, dc, exp_dc);
    chk({tag, "_busy_cnt"}, bc, exp_dc - 1);
    chk({tag, "_busy_at_done"}, busy_o, 1);
    chk({tag, "_fitness"}, fit_o, ref_fit(c, t));
    chk({tag, "_perfect"}, perf_o, (ref_fit(c, t) == 16));
`ifdef FITNESS_ERR_MAP_EN
    chk({tag, "_err_map"}, err_o, ref_err(c, t));
`endif
    step();
    chk({tag, "_done_low"}, done_o, 0);
    chk({tag, "_idle"}, busy_o, 0);
  endtask

  initial begin
    int dc, bc, nd, d1, d2;
    logic [4:0]  fit_cap;
    logic [15:0] t;

    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
    target_a = '0; target_b = '0;
    sel = 1'b0; dly_a = 1'b0; circ = 16'hE4E4;
    repeat (3) step();
    chk("rst_dut_in", in_a, 0);
    chk("rst_busy",   busy_a, 0);
    chk("rst_done",   done_a, 0);
    chk("rst_fit",    fit_a, 0);
    chk("rst_perf",   perf_a, 0);
    chk("rst3_busy",  busy_b, 0);
    chk("rst3_fit",   fit_b, 0);
`ifdef FITNESS_ERR_MAP_EN
    chk("rst_err",    err_a, 0);
`endif
    rst_n = 1'b1;
    step();

    // Identity circuit against the matching, inverted and one-off targets.
    check_run("match", circ, 16'hE4E4, 17);
    chk("dut_in_hold", in_a, 7);
    check_run("invert", circ, 16'h1B1B, 17);
    check_run("one_off", circ, 16'hE4E5, 17);

    // start re-pulsed and target changed mid-run: must be ignored.
    launch(16'hE4E4);
    nd = 0; d1 = 0; fit_cap = '0;
    for (int n = 1; n <= 45; n++) begin
      if (n == 5) begin start_a = 1'b1; target_a = 16'h0000; end
      if (n == 6) start_a = 1'b0;
      if (done_o) begin
        nd++;
        if (d1 == 0) begin d1 = n; fit_cap = fit_o; end
      end
      step();
    end
    chk("ignore_n_done", nd, 1);
    chk("ignore_done_cyc", d1, 17);
    chk("ignore_fit", fit_cap, 16);

    // Reset pulse at cycle 8 aborts the run without a done.
    launch(16'hE4E4);
    repeat (7) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("abort_fit", fit_o, 0);
    chk("abort_dut_in", in_a, 0);
    chk("abort_busy", busy_o, 0);
    nd = 0;
    for (int n = 0; n < 25; n++) begin
      if (done_o) nd++;
      step();
    end
    chk("abort_no_done", nd, 0);
    check_run("after_abort", circ, 16'hE4E4, 17);

    // start held high: back-to-back runs with one idle cycle in between.
    start_a = 1'b1; target_a = 16'hE4E5;
    step();
    nd = 0; d1 = 0; d2 = 0;
    for (int n = 1; n <= 40; n++) begin
      if (done_o) begin
        nd++;
        if (nd == 1) d1 = n;
        if (nd == 2) d2 = n;
      end
      step();
    end
    start_a = 1'b0;
    chk("b2b_n_done", nd, 2);
    chk("b2b_first", d1, 17);
    chk("b2b_second", d2, 35);
    repeat (30) step();
    chk("b2b_drained", busy_o, 0);

    // Random circuits and targets against the reference model.
    for (int i = 0; i < 8; i++) begin
      circ = 16'($urandom);
      t = (i == 3) ? circ : 16'($urandom);
      check_run($sformatf("rand%0d", i), circ, t, 17);
    end

    // Slow circuit: SETTLE=3 covers the lag, SETTLE=1 does not.
    circ = 16'hE4E4;
    sel = 1'b1;
    launch(16'hE4E4);
    wait_done(80, dc, bc);
    chk("settle3_done_cyc", dc, 33);
    chk("settle3_busy_cnt", bc, 32);
    chk("settle3_fit", fit_o, 16);
    chk("settle3_perf", perf_o, 1);
    step();

    sel = 1'b0;
    dly_a = 1'b1;
    launch(16'hE4E4);
    wait_done(80, dc, bc);
    chk("settle1_slow_done_cyc", dc, 17);
    chk("settle1_slow_short", (fit_o < 5'd16), 1);
    chk("settle1_slow_perf", perf_o, 0);
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
